// File: rtl/thres_cfg_loader.sv
// Threshold table configuration loader: streams a header plus payload words into
// a 4*DEPTH word table space, with optional read-back checksum verification.
module thres_cfg_loader #(
  parameter int unsigned BITWIDTH = 32,
  parameter int unsigned DEPTH    = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BITWIDTH-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                cfg_we,
  output logic                cfg_re,
  output logic [15:0]         cfg_addr,
  output logic [BITWIDTH-1:0] cfg_din,
  input  logic [BITWIDTH-1:0] cfg_dout,
  output logic                busy,
  output logic                done,
  output logic [1:0]          err_code
);

  typedef enum logic [2:0] {IDLE, WRITE, DRAIN, READ, FLUSH, CHECK} state_t;

  localparam logic [16:0] LIMIT = 17'(4 * DEPTH);

  state_t              state;
  logic [15:0]         base;
  logic [10:0]         count;
  logic [10:0]         idx;
  logic                verify;
  logic [BITWIDTH-1:0] wr_sum;
  logic [BITWIDTH-1:0] rd_sum;
  logic                re_q;
  logic                wdone;
  logic                accept;
  logic                last;
  logic [10:0]         hdr_n;
  logic [15:0]         hdr_base;

  assign hdr_base = s_data[15:0];
  assign hdr_n    = s_data[26:16];
  assign s_ready  = !rst && (state == IDLE || state == WRITE || state == DRAIN);
  assign busy     = (state != IDLE);
  assign accept   = s_valid && s_ready;
  assign last     = (idx == count - 11'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      base     <= '0;
      count    <= '0;
      idx      <= '0;
      verify   <= 1'b0;
      wr_sum   <= '0;
      rd_sum   <= '0;
      re_q     <= 1'b0;
      wdone    <= 1'b0;
      cfg_we   <= 1'b0;
      cfg_re   <= 1'b0;
      cfg_addr <= '0;
      cfg_din  <= '0;
      done     <= 1'b0;
      err_code <= '0;
    end else begin
      cfg_we <= 1'b0;
      cfg_re <= 1'b0;
      wdone  <= 1'b0;
      done   <= wdone;
      // Read data returns one cycle after the strobe, so accumulate off a delayed copy.
      re_q   <= cfg_re;
      if (re_q) rd_sum <= rd_sum + cfg_dout;

      case (state)
        IDLE: begin
          if (accept) begin
            base     <= hdr_base;
            count    <= hdr_n;
            verify   <= s_data[31];
            wr_sum   <= '0;
            rd_sum   <= '0;
            err_code <= '0;
            idx      <= '0;
            if (hdr_n == 11'd0)
              done <= 1'b1;
            else if ({1'b0, hdr_base} + 17'(hdr_n) > LIMIT)
              state <= DRAIN;
            else
              state <= WRITE;
          end
        end
        WRITE: begin
          if (accept) begin
            cfg_we   <= 1'b1;
            cfg_addr <= base + 16'(idx);
            cfg_din  <= s_data;
            wr_sum   <= wr_sum + s_data;
            idx      <= idx + 11'd1;
            if (last) begin
              idx <= '0;
              if (verify) begin
                state <= READ;
              end else begin
                // Delay done by one cycle so it lands after the final write strobe.
                wdone <= 1'b1;
                state <= IDLE;
              end
            end
          end
        end
        DRAIN: begin
          if (accept) begin
            idx <= idx + 11'd1;
            if (last) begin
              done     <= 1'b1;
              err_code <= 2'd1;
              state    <= IDLE;
            end
          end
        end
        READ: begin
          cfg_re   <= 1'b1;
          cfg_addr <= base + 16'(idx);
          idx      <= idx + 11'd1;
          if (last) state <= FLUSH;
        end
        FLUSH: begin
          // Exit once the last returned word is being summed this edge.
          if (re_q && !cfg_re) state <= CHECK;
        end
        CHECK: begin
          done     <= 1'b1;
          err_code <= (rd_sum != wr_sum) ? 2'd2 : 2'd0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
